uart_msg_printer: RTL and testbench
===================================

Name: uart_msg_printer

Overview:
Parametrised successor to the fixed three-byte answer printer. It latches an N-byte message on a start pulse and serialises it over an internal 8N1 UART transmitter. Bytes go out as raw values or as uppercase ASCII hex, with an optional CR/LF terminator. It sits between the game logic and the board UART pin and reports busy/done to the controlling FSM.

Parameters:
NUM_BYTES, 3, message length in bytes (>=1)
CLKS_PER_BIT, 434, clock cycles per UART bit (>=2; 434 = 50 MHz / 115200)
GAP_CYCLES, 1000, idle-high cycles inserted between consecutive characters (0 allowed)
HEX_MODE, 0, 0 = raw bytes; 1 = each byte sent as two uppercase ASCII hex chars, high nibble first
APPEND_CRLF, 0, 1 = append 0x0D then 0x0A after the message

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-low
start  input  1  one-cycle request; sampled only while idle
msg_data  input  NUM_BYTES*8  message; bits [NUM_BYTES*8-1 -: 8] are sent first
uart_dout  output  1  UART TX line, idle high
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse after the last stop bit completes

Behaviour:
- Reset (rst=0, async): uart_dout=1, busy=0, done=0; all counters cleared; state IDLE. Reset mid-frame aborts immediately. The line returns high, with no partial-character recovery.
- Total chars C = NUM_BYTES*(HEX_MODE?2:1) + (APPEND_CRLF?2:0).
- Char order: message bytes MSB-first. In HEX_MODE each nibble n maps to 0x30+n for n<10 and 0x37+n for n>=10. CR/LF come last.
- Accept: start=1 sampled in IDLE latches msg_data into an internal shadow register. Later msg_data changes do not affect the frame. start is ignored while busy or during the done cycle.
- States: IDLE -> START_BIT -> DATA_BITS -> STOP_BIT -> (GAP -> START_BIT | DONE) -> IDLE.
- Latency: on the clock edge that samples start, busy goes to 1 and uart_dout goes to 0 (start bit).
- Each bit is held exactly CLKS_PER_BIT cycles. Data bits go out LSB first, then one stop bit (1).
- One character = 10*CLKS_PER_BIT cycles.
- Between characters: GAP_CYCLES cycles with uart_dout=1. If GAP_CYCLES=0, the next start bit immediately follows the stop bit.
- After the last char's stop bit there is no gap: done=1 and busy=0 on the same cycle, then IDLE.
- The next start may be accepted on the cycle after done.
- Frame duration from start edge to done edge = C*10*CLKS_PER_BIT + (C-1)*GAP_CYCLES cycles.
- Counter widths: bit counter $clog2(CLKS_PER_BIT); gap counter $clog2(GAP_CYCLES+1), minimum 1 bit; char index $clog2(C+1). No wrap occurs within a frame.
- start and reset deasserting together: reset has priority; start in that cycle is ignored.

Test Plan:
1. Reset mid-operation: rst low during a data bit of char 2 -> uart_dout=1, busy=0 within the same cycle (async); no done pulse; a fresh start afterwards sends the full message from byte 0.
2. Default raw mode, CLKS_PER_BIT=4, GAP_CYCLES=3, msg_data=24'hA5_3C_0F, one-cycle start -> decoded bytes A5,3C,0F. Each bit lasts 4 cycles. There are 3 idle cycles between chars. done occurs 3*40+2*3=126 cycles after start; busy high for exactly those cycles.
3. HEX_MODE=1, APPEND_CRLF=1, NUM_BYTES=2, msg_data=16'h9F2B -> chars '9','F','2','B',0x0D,0x0A (0x39,0x46,0x32,0x42,0x0D,0x0A); C=6.
4. GAP_CYCLES=0, NUM_BYTES=1, msg_data=8'h00 -> line low for 9*CLKS_PER_BIT (start plus 8 zero bits), then high for CLKS_PER_BIT, then done.
5. start re-pulsed while busy, and msg_data changed mid-frame -> transmitted bytes equal the values latched at the original start; no second frame.
6. Back-to-back: start asserted on the cycle after done -> new frame begins with no extra idle; uart_dout falls on the accepting edge.

Source files
------------

// File: rtl/uart_msg_printer.sv
// Latches an N-byte message on start and sends it over an 8N1 UART,
// as raw bytes or uppercase ASCII hex, with an optional CR/LF terminator.
//
// state     | meaning
// ----------+-------------------------------------------------
// IDLE      | line high, waiting for start
// START_BIT | line low for one bit time
// DATA_BITS | eight data bits, LSB first
// STOP_BIT  | line high for one bit time
// GAP       | idle-high spacing between characters
// DONE      | one-cycle done pulse, start ignored
module uart_msg_printer #(
  parameter int NUM_BYTES    = 3,
  parameter int CLKS_PER_BIT = 434,
  parameter int GAP_CYCLES   = 1000,
  parameter int HEX_MODE     = 0,
  parameter int APPEND_CRLF  = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [NUM_BYTES*8-1:0] msg_data,
  output logic                   uart_dout,
  output logic                   busy,
  output logic                   done
);

  localparam int MW         = NUM_BYTES * 8;
  localparam int DATA_CHARS = NUM_BYTES * ((HEX_MODE != 0) ? 2 : 1);
  localparam int NUM_CHARS  = DATA_CHARS + ((APPEND_CRLF != 0) ? 2 : 0);
  localparam int BW         = $clog2(CLKS_PER_BIT);
  localparam int GW         = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int CW         = $clog2(NUM_CHARS + 1);

  localparam logic [BW-1:0] BIT_LOAD     = BW'(CLKS_PER_BIT - 1);
  localparam logic [GW-1:0] GAP_LOAD     = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;
  localparam logic [CW-1:0] DATA_CHARS_C = CW'(DATA_CHARS);
  localparam logic [CW-1:0] LAST_CHAR    = CW'(NUM_CHARS - 1);

  typedef enum logic [2:0] {
    IDLE, START_BIT, DATA_BITS, STOP_BIT, GAP, DONE
  } state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
  logic [CW-1:0]   char_idx_q, char_idx_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic            nib_q, nib_d;
  logic [7:0]      shift_q, shift_d;
  logic [MW-1:0]   msg_q, msg_d;
  logic            dout_q, dout_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [3:0]      nib;
  logic [7:0]      cur_char;
  logic            bit_tick;

  // The shadow register is shifted left as bytes are consumed, so the
  // character to send always comes from its top byte.
  always_comb begin
    nib = nib_q ? msg_q[MW-5 -: 4] : msg_q[MW-1 -: 4];
    if (char_idx_q >= DATA_CHARS_C) begin
      cur_char = (char_idx_q == DATA_CHARS_C) ? 8'h0D : 8'h0A;
    end else if (HEX_MODE != 0) begin
      cur_char = (nib < 4'd10) ? {4'h3, nib} : 8'h37 + {4'h0, nib};
    end else begin
      cur_char = msg_q[MW-1 -: 8];
    end
  end

  assign bit_tick = (bit_cnt_q == '0);

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    char_idx_d = char_idx_q;
    bit_idx_d  = bit_idx_q;
    nib_d      = nib_q;
    shift_d    = shift_q;
    msg_d      = msg_q;
    dout_d     = dout_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = START_BIT;
          msg_d      = msg_data;
          char_idx_d = '0;
          nib_d      = 1'b0;
          bit_cnt_d  = BIT_LOAD;
          dout_d     = 1'b0;
          busy_d     = 1'b1;
        end
      end
      START_BIT: begin
        if (bit_tick) begin
          state_d   = DATA_BITS;
          shift_d   = cur_char;
          dout_d    = cur_char[0];
          bit_idx_d = 3'd7;
          bit_cnt_d = BIT_LOAD;
        end else begin
          bit_cnt_d = bit_cnt_q - 1'b1;
        end
      end
      DATA_BITS: begin
        if (bit_tick) begin
          bit_cnt_d = BIT_LOAD;
          if (bit_idx_q == 3'd0) begin
            state_d = STOP_BIT;
            dout_d  = 1'b1;
          end else begin
            shift_d   = shift_q >> 1;
            dout_d    = shift_q[1];
            bit_idx_d = bit_idx_q - 1'b1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q - 1'b1;
        end
      end
      STOP_BIT: begin
        if (bit_tick) begin
          char_idx_d = char_idx_q + 1'b1;
          if (char_idx_q < DATA_CHARS_C) begin
            if ((HEX_MODE != 0) && !nib_q) begin
              nib_d = 1'b1;
            end else begin
              nib_d = 1'b0;
              msg_d = msg_q << 8;
            end
          end
          if (char_idx_q == LAST_CHAR) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else if (GAP_CYCLES > 0) begin
            state_d   = GAP;
            gap_cnt_d = GAP_LOAD;
          end else begin
            state_d   = START_BIT;
            bit_cnt_d = BIT_LOAD;
            dout_d    = 1'b0;
          end
        end else begin
          bit_cnt_d = bit_cnt_q - 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt_q == '0) begin
          state_d   = START_BIT;
          bit_cnt_d = BIT_LOAD;
          dout_d    = 1'b0;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        dout_d  = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      char_idx_q <= '0;
      bit_idx_q  <= '0;
      nib_q      <= 1'b0;
      shift_q    <= '0;
      msg_q      <= '0;
      dout_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      char_idx_q <= char_idx_d;
      bit_idx_q  <= bit_idx_d;
      nib_q      <= nib_d;
      shift_q    <= shift_d;
      msg_q      <= msg_d;
      dout_q     <= dout_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign uart_dout = dout_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_uart_msg_printer.sv
// Scoreboard bench for uart_msg_printer: three configurations (raw with gap,
// hex with CR/LF, single byte without gap) decoded by per-instance UART monitors.
module tb_uart_msg_printer;

  localparam int CPB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start0, start1, start2;
  logic [23:0] msg0;
  logic [15:0] msg1;
  logic [7:0]  msg2;
  logic        dout0, dout1, dout2;
  logic        busy0, busy1, busy2;
  logic        done0, done1, done2;
  logic [2:0]  line, busy_v, done_v;

  assign line   = {dout2, dout1, dout0};
  assign busy_v = {busy2, busy1, busy0};
  assign done_v = {done2, done1, done0};

  uart_msg_printer #(.NUM_BYTES(3), .CLKS_PER_BIT(CPB), .GAP_CYCLES(3),
                     .HEX_MODE(0), .APPEND_CRLF(0)) dut0 (
    .clk(clk), .rst(rst_n), .start(start0), .msg_data(msg0),
    .uart_dout(dout0), .busy(busy0), .done(done0));

  uart_msg_printer #(.NUM_BYTES(2), .CLKS_PER_BIT(CPB), .GAP_CYCLES(0),
                     .HEX_MODE(1), .APPEND_CRLF(1)) dut1 (
    .clk(clk), .rst(rst_n), .start(start1), .msg_data(msg1),
    .uart_dout(dout1), .busy(busy1), .done(done1));

  uart_msg_printer #(.NUM_BYTES(1), .CLKS_PER_BIT(CPB), .GAP_CYCLES(0),
                     .HEX_MODE(0), .APPEND_CRLF(0)) dut2 (
    .clk(clk), .rst(rst_n), .start(start2), .msg_data(msg2),
    .uart_dout(dout2), .busy(busy2), .done(done2));

  int n_checks = 0;
  int n_pass   = 0;
  int dcnt0 = 0, dcnt1 = 0, dcnt2 = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] q2[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Waits for a start bit, then samples each bit at its first falling clock edge.
  task automatic rx_char(input int k, output logic [7:0] ch, output bit aborted,
                         output logic stop);
    aborted = 1'b0;
    ch = '0;
    @(negedge clk);
    while (!(rst_n === 1'b1 && line[k] === 1'b0)) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      if (rst_n !== 1'b1) aborted = 1'b1;
      ch[i] = line[k];
    end
    repeat (CPB) @(negedge clk);
    if (rst_n !== 1'b1) aborted = 1'b1;
    stop = line[k];
  endtask

  task automatic got_char(input int k, input logic [7:0] ch, input logic stop);
    logic [7:0] e;
    bit have;
    e = '0;
    have = 1'b0;
    case (k)
      0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
    endcase
    if (!have) begin
      n_checks++;
      $display("FAIL dut%0d unexpected char: got %02h, expected none", k, ch);
    end else begin
      chk($sformatf("dut%0d char", k), {24'b0, ch}, {24'b0, e});
    end
    chk($sformatf("dut%0d stop bit", k), 32'(stop), 32'd1);
  endtask

  initial begin : mon0
    logic [7:0] ch; bit ab; logic sb;
    forever begin
      rx_char(0, ch, ab, sb);
      if (!ab) got_char(0, ch, sb);
    end
  end

  initial begin : mon1
    logic [7:0] ch; bit ab; logic sb;
    forever begin
      rx_char(1, ch, ab, sb);
      if (!ab) got_char(1, ch, sb);
    end
  end

  initial begin : mon2
    logic [7:0] ch; bit ab; logic sb;
    forever begin
      rx_char(2, ch, ab, sb);
      if (!ab) got_char(2, ch, sb);
    end
  end

  initial begin : done_counter
    forever begin
      @(negedge clk);
      if (done0 === 1'b1) dcnt0++;
      if (done1 === 1'b1) dcnt1++;
      if (done2 === 1'b1) dcnt2++;
    end
  end

  // Called at the first falling edge after the accepting edge.
  task automatic run_frame_check(input int k, input int exp_len, input string tag);
    int n, bcnt;
    bit seen;
    chk({tag, " accept busy"}, 32'(busy_v[k]), 32'd1);
    chk({tag, " accept dout"}, 32'(line[k]), 32'd0);
    n = 0; bcnt = 1; seen = 1'b0;
    while (n < exp_len + 50 && !seen) begin
      @(negedge clk);
      n++;
      if (done_v[k] === 1'b1) seen = 1'b1;
      else if (busy_v[k] === 1'b1) bcnt++;
    end
    chk({tag, " done latency"}, 32'(n), 32'(exp_len));
    chk({tag, " busy cycles"}, 32'(bcnt), 32'(exp_len));
    chk({tag, " busy at done"}, 32'(busy_v[k]), 32'd0);
  endtask

  initial begin : main
    int d_before, n, n_low, n_high;
    rst_n = 1'b0;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    msg0 = '0; msg1 = '0; msg2 = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset dout%0d", k), 32'(line[k]), 32'd1);
      chk($sformatf("reset busy%0d", k), 32'(busy_v[k]), 32'd0);
      chk($sformatf("reset done%0d", k), 32'(done_v[k]), 32'd0);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // raw mode with gap
    q0.push_back(8'hA5); q0.push_back(8'h3C); q0.push_back(8'h0F);
    msg0 = 24'hA5_3C_0F; start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    run_frame_check(0, 126, "raw");
    repeat (10) @(negedge clk);

    // reset during a data bit of the second character
    q0.push_back(8'hA1); q0.push_back(8'hB2); q0.push_back(8'hC3);
    msg0 = 24'hA1_B2_C3; start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    d_before = dcnt0;
    repeat (55) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset dout", 32'(dout0), 32'd1);
    chk("midreset busy", 32'(busy0), 32'd0);
    chk("midreset done", 32'(done0), 32'd0);
    repeat (8) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    chk("no done after abort", 32'(dcnt0), 32'(d_before));
    chk("chars left after abort", 32'(q0.size()), 32'd2);
    q0.delete();

    q0.push_back(8'hC3); q0.push_back(8'h81); q0.push_back(8'h7E);
    msg0 = 24'hC3_81_7E; start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    run_frame_check(0, 126, "after reset");
    repeat (10) @(negedge clk);

    // restart and message change while busy
    q0.push_back(8'h5A); q0.push_back(8'h00); q0.push_back(8'hFF);
    msg0 = 24'h5A_00_FF; start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    fork
      begin
        repeat (30) @(negedge clk);
        msg0 = 24'h11_22_33; start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
      end
    join_none
    run_frame_check(0, 126, "restart ignored");

    // back-to-back: start in the cycle after done
    q0.push_back(8'h80); q0.push_back(8'h01); q0.push_back(8'h7F);
    msg0 = 24'h80_01_7F;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    run_frame_check(0, 126, "back2back");
    repeat (10) @(negedge clk);

    // hex with CR/LF
    q1.push_back(8'h39); q1.push_back(8'h46); q1.push_back(8'h32);
    q1.push_back(8'h42); q1.push_back(8'h0D); q1.push_back(8'h0A);
    msg1 = 16'h9F2B; start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    run_frame_check(1, 240, "hex crlf");
    repeat (10) @(negedge clk);

    // single zero byte, no gap: 9 low bit times then one high
    q2.push_back(8'h00);
    msg2 = 8'h00; start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    chk("gap0 accept busy", 32'(busy2), 32'd1);
    n = 0; n_low = 1; n_high = 0;
    while (line[2] === 1'b0 && n < 200) begin
      @(negedge clk); n++;
      if (line[2] === 1'b0) n_low++;
    end
    while (done2 !== 1'b1 && n < 200) begin
      if (line[2] === 1'b1) n_high++;
      @(negedge clk); n++;
    end
    chk("gap0 low cycles", 32'(n_low), 32'(9 * CPB));
    chk("gap0 high cycles", 32'(n_high), 32'(CPB));
    chk("gap0 done latency", 32'(n), 32'(10 * CPB));
    chk("gap0 busy at done", 32'(busy2), 32'd0);
    repeat (20) @(negedge clk);

    chk("dut0 chars outstanding", 32'(q0.size()), 32'd0);
    chk("dut1 chars outstanding", 32'(q1.size()), 32'd0);
    chk("dut2 chars outstanding", 32'(q2.size()), 32'd0);
    chk("dut0 done count", 32'(dcnt0), 32'd4);
    chk("dut1 done count", 32'(dcnt1), 32'd1);
    chk("dut2 done count", 32'(dcnt2), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
